// File: rtl/keypad_bcd_capture_if.sv
// Keypad capture bus: raw key lines and clear in, accepted-key and digit-buffer status out.
//   d         raw one-hot key lines, bit i = key i
//   clear     synchronous digit-buffer clear
//   key_bcd   index of the last accepted key
//   key_valid one-cycle pulse per accepted key
//   digits    digit buffer, newest in [3:0]
//   count     number of stored digits
//   full      buffer holds DIGITS digits
//   overrun   one-cycle pulse, key accepted while full
//   multi_err more than one key line set in the registered sample
interface keypad_bcd_capture_if #(
  parameter int unsigned N_KEYS = 10,
  parameter int unsigned DIGITS = 4
);
  logic [N_KEYS-1:0]   d;
  logic                clear;
  logic [3:0]          key_bcd;
  logic                key_valid;
  logic [4*DIGITS-1:0] digits;
  logic [3:0]          count;
  logic                full;
  logic                overrun;
  logic                multi_err;

  modport master (
    output d, clear,
    input  key_bcd, key_valid, digits, count, full, overrun, multi_err
  );

  modport slave (
    input  d, clear,
    output key_bcd, key_valid, digits, count, full, overrun, multi_err
  );
endinterface

// File: rtl/keypad_bcd_capture.sv
// Debounced one-hot keypad capture: each accepted key-down is encoded to its
// 4-bit index and appended to a DIGITS-deep digit buffer (no wrap-around).
//   clock  rising-edge clock
//   reset  asynchronous, active-high
//   bus    keypad_bcd_capture_if slave (d/clear in; key, buffer and status out)
module keypad_bcd_capture #(
  parameter int unsigned N_KEYS   = 10,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned DEBOUNCE = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  keypad_bcd_capture_if.slave   bus
);

  localparam int unsigned DW = 4 * DIGITS;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state;
  logic [N_KEYS-1:0] d_q;
  logic [CW-1:0]     cnt;
  logic [3:0]        cand;
  logic [3:0]        key_bcd;
  logic              key_valid;
  logic [DW-1:0]     digits;
  logic [3:0]        count;
  logic              overrun;

  logic              is_zero;
  logic              is_one;
  logic [3:0]        code;
  logic [CW-1:0]     cnt_inc;
  logic              accept;

  // Index of the set bit in the registered sample (meaningful only when is_one).
  always_comb begin
    code = 4'd0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      if (d_q[i]) code = 4'(i);
    end
  end

  // Clearing the lowest set bit leaves zero exactly when at most one bit is set.
  assign is_zero = (d_q == '0);
  assign is_one  = !is_zero && ((d_q & (d_q - N_KEYS'(1))) == '0);
  assign cnt_inc = cnt + CW'(1);

  // A key is accepted on the sample that completes DEBOUNCE equal one-hot samples.
  always_comb begin
    accept = 1'b0;
    case (state)
      IDLE:    accept = is_one && (DEBOUNCE == 1);
      CHECK:   accept = is_one && (code == cand) && (cnt_inc == CW'(DEBOUNCE));
      default: accept = 1'b0;
    endcase
  end

  // Input sampling, debounce FSM, key reporting and digit buffer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      d_q       <= '0;
      cnt       <= '0;
      cand      <= 4'd0;
      key_bcd   <= 4'd0;
      key_valid <= 1'b0;
      digits    <= '0;
      count     <= 4'd0;
      overrun   <= 1'b0;
    end else begin
      d_q       <= bus.d;
      key_valid <= accept;
      overrun   <= 1'b0;

      if (accept) key_bcd <= code;

      // clear takes priority over storing a digit accepted on the same edge
      if (bus.clear) begin
        digits <= '0;
        count  <= 4'd0;
      end else if (accept) begin
        if (count < 4'(DIGITS)) begin
          digits <= (digits << 4) | DW'(code);
          count  <= count + 4'd1;
        end else begin
          overrun <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (is_one) begin
            cand  <= code;
            cnt   <= CW'(1);
            state <= (DEBOUNCE == 1) ? HELD : CHECK;
          end
        end
        CHECK: begin
          if (is_one) begin
            if (code == cand) begin
              if (cnt_inc == CW'(DEBOUNCE)) state <= HELD;
              else                          cnt   <= cnt_inc;
            end else begin
              cand <= code;
              cnt  <= CW'(1);
            end
          end else begin
            state <= IDLE;
          end
        end
        HELD: begin
          // any non-zero sample, including a rollover to another key, keeps the key held
          if (is_zero) begin
            cnt   <= CW'(1);
            state <= (DEBOUNCE == 1) ? IDLE : RELEASE;
          end
        end
        RELEASE: begin
          if (is_zero) begin
            if (cnt_inc == CW'(DEBOUNCE)) state <= IDLE;
            else                          cnt   <= cnt_inc;
          end else begin
            state <= HELD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.key_bcd   = key_bcd;
  assign bus.key_valid = key_valid;
  assign bus.digits    = digits;
  assign bus.count     = count;
  assign bus.overrun   = overrun;
  assign bus.full      = (count == 4'(DIGITS));
  assign bus.multi_err = !is_zero && !is_one;

endmodule

// File: tb/tb_keypad_bcd_capture.sv
// Bench for keypad_bcd_capture: a per-cycle vector table and hand sequences on a
// 10-key/4-digit/debounce-2 instance, a 12-key/2-digit/debounce-1 instance, and a
// random phase on both checked against a run-length reference model.
`timescale 1ns/1ps
module tb_keypad_bcd_capture;

  localparam int unsigned NK0 = 10, DG0 = 4, DB0 = 2;
  localparam int unsigned NK1 = 12, DG1 = 2, DB1 = 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  keypad_bcd_capture_if #(.N_KEYS(NK0), .DIGITS(DG0)) if0 ();
  keypad_bcd_capture_if #(.N_KEYS(NK1), .DIGITS(DG1)) if1 ();

  keypad_bcd_capture #(.N_KEYS(NK0), .DIGITS(DG0), .DEBOUNCE(DB0)) dut0 (
    .clock(clock), .reset(reset), .bus(if0)
  );
  keypad_bcd_capture #(.N_KEYS(NK1), .DIGITS(DG1), .DEBOUNCE(DB1)) dut1 (
    .clock(clock), .reset(reset), .bus(if1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- vector table (instance 0) ----------------
  typedef struct {
    logic [9:0]  d;
    logic        clr;
    logic        v;
    logic [3:0]  bcd;
    logic [3:0]  cnt;
    logic [15:0] dig;
    logic        ovr;
  } vec_t;

  vec_t        tbl[$];
  logic [3:0]  t_bcd;
  logic [3:0]  t_cnt;
  logic [15:0] t_dig;

  task automatic add_row(input logic [9:0] d, input logic c, input logic v, input logic o);
    vec_t r;
    r.d = d; r.clr = c; r.v = v; r.bcd = t_bcd; r.cnt = t_cnt; r.dig = t_dig; r.ovr = o;
    tbl.push_back(r);
  endtask

  // Full press of key k from idle: accept on the third row, released and idle after six.
  task automatic add_press(input int unsigned k, input logic clr_acc, input logic [3:0] cnt_after,
                           input logic [15:0] dig_after, input logic ovr);
    logic [9:0] oh;
    oh = 10'(1) << k;
    add_row(oh, 1'b0, 1'b0, 1'b0);
    add_row(oh, 1'b0, 1'b0, 1'b0);
    t_bcd = 4'(k); t_cnt = cnt_after; t_dig = dig_after;
    add_row(oh, clr_acc, 1'b1, ovr);
    add_row(10'h000, 1'b0, 1'b0, 1'b0);
    add_row(10'h000, 1'b0, 1'b0, 1'b0);
    add_row(10'h000, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- reference model ----------------
  // Expressed as run lengths: a key counts once DEBOUNCE consecutive identical
  // one-hot samples arrive while no key is held; a held key is released after
  // DEBOUNCE consecutive empty samples. The buffer is an append-ordered list.
  logic [15:0] m_dq[2];
  bit          m_held[2];
  int          m_run[2];
  int          m_rcode[2];
  int          m_zero[2];
  bit          m_valid[2];
  bit          m_ovr[2];
  int          m_bcd[2];
  int          m_list[2][8];
  int          m_n[2];
  int          m_deb[2];
  int          m_ndig[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_dq[i] = '0; m_held[i] = 0; m_run[i] = 0; m_rcode[i] = 0; m_zero[i] = 0;
      m_valid[i] = 0; m_ovr[i] = 0; m_bcd[i] = 0; m_n[i] = 0;
    end
    m_deb[0] = DB0; m_deb[1] = DB1; m_ndig[0] = DG0; m_ndig[1] = DG1;
  endtask

  task automatic model_edge(input int i, input logic [15:0] nd, input bit clr);
    logic [15:0] s;
    int code;
    bit acc;
    s = m_dq[i];
    m_dq[i] = nd;
    acc = 0;
    code = 0;
    for (int b = 0; b < 16; b++) if (s[b]) code = b;
    if (!m_held[i]) begin
      if ($countones(s) == 1) begin
        if (m_run[i] > 0 && m_rcode[i] == code) m_run[i]++;
        else begin m_rcode[i] = code; m_run[i] = 1; end
        if (m_run[i] == m_deb[i]) begin acc = 1; m_held[i] = 1; m_zero[i] = 0; end
      end else begin
        m_run[i] = 0;
      end
    end else if (s == 16'h0000) begin
      m_zero[i]++;
      if (m_zero[i] == m_deb[i]) begin m_held[i] = 0; m_run[i] = 0; end
    end else begin
      m_zero[i] = 0;
    end
    m_valid[i] = acc;
    m_ovr[i] = 0;
    if (acc) m_bcd[i] = code;
    if (clr) m_n[i] = 0;
    else if (acc) begin
      if (m_n[i] < m_ndig[i]) begin m_list[i][m_n[i]] = code; m_n[i]++; end
      else m_ovr[i] = 1;
    end
  endtask

  function automatic logic [31:0] model_digits(input int i);
    logic [31:0] v;
    v = '0;
    for (int j = 0; j < m_n[i]; j++) v = v | (32'(m_list[i][m_n[i] - 1 - j]) << (4 * j));
    return v;
  endfunction

  task automatic cmp_model(input int i);
    logic [31:0] v, b, c, g, f, o, me;
    if (i == 0) begin
      v = 32'(if0.key_valid); b = 32'(if0.key_bcd); c = 32'(if0.count); g = 32'(if0.digits);
      f = 32'(if0.full); o = 32'(if0.overrun); me = 32'(if0.multi_err);
    end else begin
      v = 32'(if1.key_valid); b = 32'(if1.key_bcd); c = 32'(if1.count); g = 32'(if1.digits);
      f = 32'(if1.full); o = 32'(if1.overrun); me = 32'(if1.multi_err);
    end
    chk($sformatf("rnd dut%0d key_valid", i), v, 32'(m_valid[i]));
    chk($sformatf("rnd dut%0d key_bcd", i), b, 32'(m_bcd[i]));
    chk($sformatf("rnd dut%0d count", i), c, 32'(m_n[i]));
    chk($sformatf("rnd dut%0d digits", i), g, model_digits(i));
    chk($sformatf("rnd dut%0d full", i), f, 32'(m_n[i] == m_ndig[i]));
    chk($sformatf("rnd dut%0d overrun", i), o, 32'(m_ovr[i]));
    chk($sformatf("rnd dut%0d multi_err", i), me, 32'($countones(m_dq[i]) > 1));
  endtask

  task automatic chk_zero0(input string tag);
    chk({tag, " key_valid"}, 32'(if0.key_valid), 32'd0);
    chk({tag, " key_bcd"},   32'(if0.key_bcd),   32'd0);
    chk({tag, " digits"},    32'(if0.digits),    32'd0);
    chk({tag, " count"},     32'(if0.count),     32'd0);
    chk({tag, " full"},      32'(if0.full),      32'd0);
    chk({tag, " overrun"},   32'(if0.overrun),   32'd0);
    chk({tag, " multi_err"}, 32'(if0.multi_err), 32'd0);
  endtask

  initial begin
    int unsigned sel, k1, k2, dur;
    logic [15:0] pat;
    bit c0, c1;
    int pulses;

    reset = 1'b1;
    if0.d = '0; if0.clear = 1'b0;
    if1.d = '0; if1.clear = 1'b0;
    model_reset();
    repeat (2) tick();
    chk_zero0("reset");
    chk("reset dut1 count", 32'(if1.count), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // ---- table: basic press, glitches, fill, overrun, clear priority ----
    t_bcd = 4'd0; t_cnt = 4'd0; t_dig = 16'h0000;
    add_row(10'h008, 1'b0, 1'b0, 1'b0);
    add_row(10'h008, 1'b0, 1'b0, 1'b0);
    t_bcd = 4'd3; t_cnt = 4'd1; t_dig = 16'h0003;
    add_row(10'h008, 1'b0, 1'b1, 1'b0);
    add_row(10'h008, 1'b0, 1'b0, 1'b0);
    add_row(10'h008, 1'b0, 1'b0, 1'b0);
    repeat (4) add_row(10'h000, 1'b0, 1'b0, 1'b0);
    add_row(10'h020, 1'b0, 1'b0, 1'b0);
    add_row(10'h000, 1'b0, 1'b0, 1'b0);
    add_row(10'h000, 1'b0, 1'b0, 1'b0);
    add_row(10'h020, 1'b0, 1'b0, 1'b0);
    add_row(10'h040, 1'b0, 1'b0, 1'b0);
    add_row(10'h040, 1'b0, 1'b0, 1'b0);
    t_bcd = 4'd6; t_cnt = 4'd2; t_dig = 16'h0036;
    add_row(10'h040, 1'b0, 1'b1, 1'b0);
    repeat (3) add_row(10'h000, 1'b0, 1'b0, 1'b0);
    t_cnt = 4'd0; t_dig = 16'h0000;
    add_row(10'h000, 1'b1, 1'b0, 1'b0);
    add_press(1, 1'b0, 4'd1, 16'h0001, 1'b0);
    add_press(2, 1'b0, 4'd2, 16'h0012, 1'b0);
    add_press(3, 1'b0, 4'd3, 16'h0123, 1'b0);
    add_press(4, 1'b0, 4'd4, 16'h1234, 1'b0);
    add_press(9, 1'b0, 4'd4, 16'h1234, 1'b1);
    t_cnt = 4'd0; t_dig = 16'h0000;
    add_row(10'h000, 1'b1, 1'b0, 1'b0);
    add_press(1, 1'b0, 4'd1, 16'h0001, 1'b0);
    add_press(2, 1'b0, 4'd2, 16'h0012, 1'b0);
    add_press(7, 1'b1, 4'd0, 16'h0000, 1'b0);
    add_press(5, 1'b0, 4'd1, 16'h0005, 1'b0);
    add_press(6, 1'b0, 4'd2, 16'h0056, 1'b0);
    add_press(7, 1'b0, 4'd3, 16'h0567, 1'b0);
    add_press(8, 1'b0, 4'd4, 16'h5678, 1'b0);
    add_press(0, 1'b1, 4'd0, 16'h0000, 1'b0);
    add_press(0, 1'b0, 4'd1, 16'h0000, 1'b0);
    t_cnt = 4'd0; t_dig = 16'h0000;
    add_row(10'h000, 1'b1, 1'b0, 1'b0);

    for (int r = 0; r < tbl.size(); r++) begin
      if0.d = tbl[r].d;
      if0.clear = tbl[r].clr;
      tick();
      chk($sformatf("row%0d key_valid", r), 32'(if0.key_valid), 32'(tbl[r].v));
      chk($sformatf("row%0d key_bcd", r),   32'(if0.key_bcd),   32'(tbl[r].bcd));
      chk($sformatf("row%0d count", r),     32'(if0.count),     32'(tbl[r].cnt));
      chk($sformatf("row%0d digits", r),    32'(if0.digits),    32'(tbl[r].dig));
      chk($sformatf("row%0d overrun", r),   32'(if0.overrun),   32'(tbl[r].ovr));
      chk($sformatf("row%0d full", r),      32'(if0.full),      32'(tbl[r].cnt == 4'd4));
    end
    if0.clear = 1'b0;

    // ---- two keys at once: flagged, never accepted ----
    if0.d = 10'h003;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("multi multi_err", 32'(if0.multi_err), 32'd1);
      chk("multi key_valid", 32'(if0.key_valid), 32'd0);
    end
    if0.d = 10'h000;
    tick();
    chk("multi cleared", 32'(if0.multi_err), 32'd0);
    chk("multi count", 32'(if0.count), 32'd0);
    tick();
    chk("multi no late accept", 32'(if0.key_valid), 32'd0);

    // ---- one-cycle release bounce returns to held without a second accept ----
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      if0.d = (c == 4 || c >= 8) ? 10'h000 : 10'h020;
      tick();
      if (if0.key_valid) pulses++;
    end
    chk("bounce accept count", 32'(pulses), 32'd1);
    chk("bounce key_bcd", 32'(if0.key_bcd), 32'd5);
    chk("bounce count", 32'(if0.count), 32'd1);
    chk("bounce digits", 32'(if0.digits), 32'h0005);

    // ---- asynchronous reset while a press is being debounced ----
    if0.d = 10'h010;
    tick();
    tick();
    chk("pre-reset count", 32'(if0.count), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk_zero0("async reset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    tick();
    chk("post-reset edge1", 32'(if0.key_valid), 32'd0);
    tick();
    chk("post-reset edge2", 32'(if0.key_valid), 32'd0);
    tick();
    chk("post-reset accept", 32'(if0.key_valid), 32'd1);
    chk("post-reset key_bcd", 32'(if0.key_bcd), 32'd4);
    if0.d = 10'h000;
    repeat (3) tick();

    // ---- 12-key, 2-digit, debounce-1 instance ----
    if1.d = 12'h800;
    tick();
    chk("k12 edge1 key_valid", 32'(if1.key_valid), 32'd0);
    tick();
    chk("k12 key_valid", 32'(if1.key_valid), 32'd1);
    chk("k12 key_bcd", 32'(if1.key_bcd), 32'hB);
    chk("k12 digits", 32'(if1.digits), 32'h0B);
    chk("k12 full", 32'(if1.full), 32'd0);
    if1.d = 12'h000;
    tick();
    chk("k12 pulse width", 32'(if1.key_valid), 32'd0);
    tick();
    if1.d = 12'h400;
    tick();
    tick();
    chk("k12 second key_bcd", 32'(if1.key_bcd), 32'hA);
    chk("k12 second digits", 32'(if1.digits), 32'hBA);
    chk("k12 full", 32'(if1.full), 32'd1);
    if1.d = 12'h000;
    repeat (2) tick();
    if1.d = 12'h001;
    tick();
    tick();
    chk("k12 overrun key_valid", 32'(if1.key_valid), 32'd1);
    chk("k12 overrun", 32'(if1.overrun), 32'd1);
    chk("k12 overrun key_bcd", 32'(if1.key_bcd), 32'd0);
    chk("k12 overrun digits", 32'(if1.digits), 32'hBA);
    if1.d = 12'h000;
    tick();
    chk("k12 overrun width", 32'(if1.overrun), 32'd0);

    // ---- random phase against the reference model ----
    reset = 1'b1;
    if0.d = '0; if1.d = '0; if0.clear = 1'b0; if1.clear = 1'b0;
    repeat (2) tick();
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    for (int burst = 0; burst < 600; burst++) begin
      sel = $urandom_range(0, 9);
      k1  = $urandom_range(0, 11);
      k2  = $urandom_range(0, 11);
      if (sel < 3)      pat = 16'h0000;
      else if (sel < 9) pat = 16'(1) << k1;
      else              pat = (16'(1) << k1) | (16'(1) << k2);
      dur = $urandom_range(1, 4);
      for (int c = 0; c < int'(dur); c++) begin
        c0 = ($urandom_range(0, 24) == 0);
        c1 = ($urandom_range(0, 24) == 0);
        if0.d = pat[9:0];
        if1.d = pat[11:0];
        if0.clear = c0;
        if1.clear = c1;
        tick();
        model_edge(0, {6'b0, pat[9:0]}, c0);
        model_edge(1, {4'b0, pat[11:0]}, c1);
        cmp_model(0);
        cmp_model(1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
